// File: rtl/spm_memory_loader_if.sv
// Bundle between the RISC_SPM core, the program-load stream and the
// unified memory/loader: load handshake plus the core's memory bus.
interface spm_memory_loader_if #(
  parameter int word_size = 8
);
  logic                 reload;
  logic                 ld_valid;
  logic [word_size-1:0] ld_data;
  logic                 ld_last;
  logic                 ld_ready;
  logic                 cpu_rst;
  logic [word_size-1:0] address;
  logic [word_size-1:0] data_in;
  logic                 write;
  logic [word_size-1:0] data_out;
  logic                 load_done;
  logic [word_size:0]   load_count;

  modport master (
    output reload,
    output ld_valid,
    output ld_data,
    output ld_last,
    output address,
    output data_in,
    output write,
    input  ld_ready,
    input  cpu_rst,
    input  data_out,
    input  load_done,
    input  load_count
  );

  modport slave (
    input  reload,
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    input  address,
    input  data_in,
    input  write,
    output ld_ready,
    output cpu_rst,
    output data_out,
    output load_done,
    output load_count
  );
endinterface

// File: rtl/spm_memory_loader.sv
// Unified 256-word memory for RISC_SPM with a streaming program loader
// that holds the core in reset until the image is in place.
module spm_memory_loader #(
  parameter int word_size = 8,
  parameter int mem_depth = 256
) (
  input logic                  clk,
  input logic                  rst,
  spm_memory_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SETTLE,
    S_RUN
  } state_e;

  localparam logic [word_size-1:0] PTR_MAX =
    word_size'(mem_depth - 1);
  localparam logic [word_size-1:0] PTR_ONE = word_size'(1);
  localparam logic [word_size:0]   CNT_ONE = (word_size + 1)'(1);

  state_e               state_q, state_d;
  logic [word_size-1:0] ptr_q, ptr_d;
  logic [word_size:0]   cnt_q, cnt_d;
  logic [word_size-1:0] mem [mem_depth];

  logic accept;
  logic at_end;
  logic core_wr;

  assign accept  = (state_q == S_LOAD) && bus.ld_valid;
  assign at_end  = (ptr_q == PTR_MAX);
  assign core_wr = (state_q == S_RUN) && bus.write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_ONE;
          // Hold at the top address so the pointer never wraps.
          ptr_d = at_end ? ptr_q : ptr_q + PTR_ONE;
          if (bus.ld_last || at_end) begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.reload) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_comb begin
    bus.ld_ready  = 1'b0;
    bus.cpu_rst   = 1'b0;
    bus.load_done = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        bus.ld_ready = 1'b1;
      end
      S_SETTLE: begin
        bus.ld_ready = 1'b0;
      end
      S_RUN: begin
        bus.cpu_rst   = 1'b1;
        bus.load_done = 1'b1;
      end
      default: begin
        bus.ld_ready = 1'b0;
      end
    endcase
  end

  assign bus.load_count = cnt_q;

  // Array has no reset; loader and core never write in the same state.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ptr_q] <= bus.ld_data;
    end else if (core_wr) begin
      mem[bus.address] <= bus.data_in;
    end
  end

  assign bus.data_out = mem[bus.address];

endmodule

// File: doc/spm_memory_loader.md
Name: spm_memory_loader

Overview:
- Unified 256-word instruction/data memory that sits directly downstream of the RISC_SPM core.
- Consumes the core's address, data_in and write outputs, and drives the core's data_out input.
- Adds a streaming program-load port with a valid/ready handshake, plus a loader FSM.
- The FSM holds the core in reset while a program image is written from address 0, then releases the core to run.

Parameters:
- word_size, 8, width of memory word and address
- mem_depth, 256, number of words (must equal 2**word_size)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- reload  input  1  single-cycle request to re-enter program load; honoured only in RUN
- ld_valid  input  1  load beat valid
- ld_data  input  word_size  load beat data
- ld_last  input  1  marks final beat of image; qualified by ld_valid
- ld_ready  output  1  loader accepts a beat this cycle
- cpu_rst  output  1  core reset, active-low (matches core's rst); 0 = core held in reset
- address  input  word_size  core address
- data_in  input  word_size  core write data
- write  input  1  core write strobe
- data_out  output  word_size  read data to core
- load_done  output  1  high while in RUN
- load_count  output  word_size+1  number of beats written by the most recent load (0..256)

Behaviour:
- States: LOAD, SETTLE, RUN. Encoding is free; the state register has async reset.
- rst asserted (at any time, including mid-load): state=LOAD, load pointer=0, load_count=0, cpu_rst=0, ld_ready=1, load_done=0. Memory array contents are not reset.
- LOAD:
  - ld_ready=1, cpu_rst=0.
  - A beat is accepted when ld_valid&&ld_ready at a rising edge.
  - On acceptance: mem[ptr]<=ld_data, ptr<=ptr+1, load_count<=load_count+1.
  - The core port's write is ignored in LOAD and SETTLE.
  - If the accepted beat has ld_last=1, or ptr==mem_depth-1: next state is SETTLE.
- SETTLE: exactly one cycle.
  - ld_ready=0, cpu_rst=0.
  - Next state is RUN.
- RUN:
  - ld_ready=0, cpu_rst=1, load_done=1.
  - Core write: if write=1 at a rising edge, mem[address]<=data_in.
  - reload=1 at a rising edge: next state is LOAD, ptr<=0, load_count<=0, cpu_rst drops to 0 from the next cycle.
  - If write and reload coincide, the write completes first.
- cpu_rst, ld_ready and load_done are registered (decoded from the state register only). No combinational path from any input to them.
- Release timing: the beat carrying ld_last is accepted at edge N. SETTLE occupies cycle N..N+1. cpu_rst=1 from edge N+1 onward (two registered steps after the beat was presented).
- data_out = mem[address], combinational asynchronous read in every state.
  - A write at edge N is visible on data_out after edge N.
- reload is ignored in LOAD and SETTLE.
- ld_valid is ignored outside LOAD. ld_last without ld_valid has no effect.
- Overflow: the 256th beat (ptr==255) forces SETTLE regardless of ld_last. load_count=256. Further beats are not accepted (ld_ready=0).
- ptr is word_size bits wide and never wraps during a load; the transition to SETTLE precedes any wrap.
- Zero-length image is not supported: LOAD waits indefinitely for at least one beat.

Test Plan:
- Reset release, then 4 beats 0x11,0x22,0x33,0x44 (last on 4th) with ld_valid held high -> mem[0..3]=11,22,33,44; load_count=4; cpu_rst rises 2 cycles after 4th beat is presented; ld_ready=0 in SETTLE/RUN.
- Beats with ld_valid toggling 1,0,1,0,1 (3 beats, last on 3rd) -> only 3 writes; load_count=3; gaps do not advance ptr.
- 260 consecutive beats of value i[7:0], no ld_last -> mem[255]=0xFF; load_count=256; RUN entered after beat 256; beats 257-260 refused (ld_ready=0).
- In RUN: write=1, address=0x80, data_in=0xA5 -> next cycle data_out=0xA5 at address 0x80. write=1 during LOAD at address 0x80 with 0x5A -> mem unchanged.
- reload pulse in RUN coinciding with write to 0x10 of 0x77 -> mem[0x10]=0x77; next cycle cpu_rst=0, ld_ready=1, load_count=0; a new 2-beat load overwrites mem[0..1] only.
- rst asserted asynchronously mid-load after 5 beats -> immediately state=LOAD, cpu_rst=0, load_count=0; the next load starts at address 0; mem[0..4] retains old data until overwritten.
